// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: VGA line prefetch into a ping-pong line buffer,
// a bulk clear engine and a valid/ready pixel writer share one RAM port.
module fb_scan_arbiter #(
   parameter int FB_W = 160,
   parameter int FB_H = 120
) (
   input  logic        VGA_clk,
   input  logic        reset,
   input  logic [9:0]  xPixel,
   input  logic [9:0]  yPixel,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [7:0]  wr_x,
   input  logic [6:0]  wr_y,
   input  logic [2:0]  wr_rgb,
   input  logic        clear_req,
   input  logic [2:0]  clear_rgb,
   output logic        clear_busy,
   output logic [14:0] mem_addr,
   output logic        mem_we,
   output logic [2:0]  mem_wdata,
   input  logic [2:0]  mem_rdata,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B
);
   localparam int          NPIX      = FB_W * FB_H;
   localparam int          LBW       = $clog2(2 * FB_W);
   localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
   localparam logic [7:0]  LAST_COL  = 8'(FB_W - 1);
   localparam logic [7:0]  FB_W8     = 8'(FB_W);
   localparam logic [6:0]  FB_H7     = 7'(FB_H);

   typedef enum logic [1:0] {F_IDLE, F_READ, F_LAST} fstate_t;
   typedef enum logic {C_IDLE, C_RUN} cstate_t;

   function automatic logic [14:0] pix_addr(input logic [6:0] y, input logic [7:0] x);
      return 15'(y) * 15'(FB_W) + 15'(x);
   endfunction

   fstate_t     r_fstate, w_fstate_next;
   cstate_t     r_cstate, w_cstate_next;
   logic [7:0]  r_col, w_col_next;
   logic [14:0] r_row_base, w_row_base_next;
   logic [14:0] r_clr_addr, w_clr_addr_next;
   logic [2:0]  r_clr_rgb, w_clr_rgb_next;
   logic [14:0] r_last_addr;
   logic        r_rd_valid, w_rd_issue;
   logic [7:0]  r_rd_idx, w_rd_idx;
   logic        r_disp_bank;
   logic        r_vga_vis;
   logic [2:0]  r_vga_pix;
   logic [2:0]  r_lb [0:2*FB_W-1];

   logic        w_trig, w_swap, w_fetch_active, w_bank_eff;
   logic [6:0]  w_trig_row;
   logic [14:0] w_trig_base;
   logic [7:0]  w_rd_col;
   logic [LBW-1:0] w_lb_wr_idx, w_lb_rd_idx;

   // Row n is fetched on the last scan line of row n-1; row 0 on the final line of the frame.
   assign w_trig = !reset && (xPixel == 10'd0) &&
                   (((yPixel[1:0] == 2'b11) && (yPixel < 10'd479)) || (yPixel == 10'd525));
   assign w_trig_row  = (yPixel == 10'd525) ? 7'd0 : yPixel[8:2] + 7'd1;
   assign w_trig_base = pix_addr(w_trig_row, 8'd0);
   assign w_swap      = (xPixel == 10'd0) && (yPixel[1:0] == 2'b00) && (yPixel < 10'd480);
   assign w_fetch_active = (r_fstate == F_READ) || w_trig;

   always_comb begin
      w_fstate_next   = r_fstate;
      w_cstate_next   = r_cstate;
      w_col_next      = r_col;
      w_row_base_next = r_row_base;
      w_clr_addr_next = r_clr_addr;
      w_clr_rgb_next  = r_clr_rgb;
      w_rd_issue      = 1'b0;
      w_rd_idx        = r_col;
      mem_addr        = r_last_addr;
      mem_we          = 1'b0;
      mem_wdata       = 3'd0;
      wr_ready        = 1'b0;
      if (!reset) begin
         if (r_fstate == F_READ) begin
            mem_addr   = r_row_base + 15'(r_col);
            w_rd_issue = 1'b1;
            w_col_next = r_col + 8'd1;
            if (r_col == LAST_COL)
               w_fstate_next = F_LAST;
         end else if (w_trig) begin
            mem_addr        = w_trig_base;
            w_rd_issue      = 1'b1;
            w_rd_idx        = 8'd0;
            w_col_next      = 8'd1;
            w_row_base_next = w_trig_base;
            w_fstate_next   = F_READ;
         end else if (r_fstate == F_LAST) begin
            w_fstate_next = F_IDLE;
         end

         if (r_cstate == C_RUN) begin
            if (!w_fetch_active) begin
               mem_we          = 1'b1;
               mem_addr        = r_clr_addr;
               mem_wdata       = r_clr_rgb;
               w_clr_addr_next = r_clr_addr + 15'd1;
               if (r_clr_addr == LAST_ADDR)
                  w_cstate_next = C_IDLE;
            end
         end else begin
            // A clear request only takes effect next cycle, so the writer still owns this one.
            if (clear_req) begin
               w_cstate_next   = C_RUN;
               w_clr_addr_next = 15'd0;
               w_clr_rgb_next  = clear_rgb;
            end
            if (!w_fetch_active) begin
               wr_ready = 1'b1;
               if (wr_valid && (wr_x < FB_W8) && (wr_y < FB_H7)) begin
                  mem_we    = 1'b1;
                  mem_addr  = pix_addr(wr_y, wr_x);
                  mem_wdata = wr_rgb;
               end
            end
         end
      end
   end

   always_ff @(posedge VGA_clk) begin
      if (reset) begin
         r_fstate    <= F_IDLE;
         r_cstate    <= C_IDLE;
         r_col       <= 8'd0;
         r_row_base  <= 15'd0;
         r_clr_addr  <= 15'd0;
         r_clr_rgb   <= 3'd0;
         r_last_addr <= 15'd0;
         r_rd_valid  <= 1'b0;
         r_rd_idx    <= 8'd0;
         r_disp_bank <= 1'b0;
         r_vga_vis   <= 1'b0;
      end else begin
         r_fstate    <= w_fstate_next;
         r_cstate    <= w_cstate_next;
         r_col       <= w_col_next;
         r_row_base  <= w_row_base_next;
         r_clr_addr  <= w_clr_addr_next;
         r_clr_rgb   <= w_clr_rgb_next;
         r_last_addr <= mem_addr;
         r_rd_valid  <= w_rd_issue;
         r_rd_idx    <= w_rd_idx;
         if (w_swap)
            r_disp_bank <= ~r_disp_bank;
         r_vga_vis   <= (xPixel < 10'd640) && (yPixel < 10'd480);
      end
   end

   // The read on a swap cycle must already see the freshly fetched bank.
   assign w_bank_eff  = r_disp_bank ^ w_swap;
   assign w_rd_col    = (xPixel < 10'd640) ? xPixel[9:2] : 8'd0;
   assign w_lb_rd_idx = w_bank_eff ? LBW'(FB_W) + LBW'(w_rd_col) : LBW'(w_rd_col);
   assign w_lb_wr_idx = r_disp_bank ? LBW'(r_rd_idx) : LBW'(FB_W) + LBW'(r_rd_idx);

   always_ff @(posedge VGA_clk) begin
      if (r_rd_valid)
         r_lb[w_lb_wr_idx] <= mem_rdata;
      r_vga_pix <= r_lb[w_lb_rd_idx];
   end

   assign clear_busy = (r_cstate == C_RUN);
   assign VGA_R = {8{r_vga_vis & r_vga_pix[2]}};
   assign VGA_G = {8{r_vga_vis & r_vga_pix[1]}};
   assign VGA_B = {8{r_vga_vis & r_vga_pix[0]}};

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter with a behavioural single-port RAM model.
module tb_fb_scan_arbiter;
   logic        VGA_clk = 1'b0;
   logic        reset;
   logic [9:0]  xPixel, yPixel;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [2:0]  wr_rgb;
   logic        clear_req;
   logic [2:0]  clear_rgb;
   logic        clear_busy;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [2:0]  mem_wdata;
   logic [2:0]  mem_rdata;
   logic [7:0]  VGA_R, VGA_G, VGA_B;

   int vectors = 0;
   int miscompares = 0;
   logic [2:0] ram [0:32767];

   fb_scan_arbiter dut (
      .VGA_clk(VGA_clk), .reset(reset), .xPixel(xPixel), .yPixel(yPixel),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
      .clear_req(clear_req), .clear_rgb(clear_rgb), .clear_busy(clear_busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   always #5 VGA_clk = ~VGA_clk;

   always @(posedge VGA_clk) begin
      if (mem_we)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic tick();
      @(posedge VGA_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge VGA_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_xy();
      xPixel = 10'd700;
      yPixel = 10'd500;
   endtask

   initial begin
      int n;
      int errs;
      int stall;
      logic [7:0] exp_g;

      reset = 1'b1; wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_rgb = 3'd0;
      clear_req = 1'b0; clear_rgb = 3'd0;
      idle_xy();
      tick(); tick();
      check("rst_vga_r", VGA_R, 8'h00);
      check("rst_vga_g", VGA_G, 8'h00);
      check("rst_vga_b", VGA_B, 8'h00);
      check("rst_busy", clear_busy, 0);
      mid();
      check("rst_ready", wr_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      tick();

      reset = 1'b0;
      mid();
      check("post_rst_ready", wr_ready, 1);
      check("post_rst_we", mem_we, 0);
      tick();

      // clear request and writer request in the same cycle: writer wins this cycle
      clear_req = 1'b1; clear_rgb = 3'b101;
      wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd5; wr_rgb = 3'b010;
      mid();
      check("simul_ready", wr_ready, 1);
      check("simul_we", mem_we, 1);
      check("simul_addr", mem_addr, 810);
      tick();
      clear_req = 1'b0; wr_valid = 1'b0;
      check("clr_rise", clear_busy, 1);

      // clear overlapped by one fetch line (row 1, y=3)
      n = 0;
      while (clear_busy === 1'b1 && n < 30000) begin
         if (n >= 1000 && n <= 1160) begin
            yPixel = 10'd3;
            xPixel = 10'(n - 1000);
         end else begin
            idle_xy();
         end
         if (n == 1000 || n == 1001) begin
            mid();
            check("fetch_r1_addr", mem_addr, 160 + n - 1000);
            check("fetch_r1_we", mem_we, 0);
         end
         tick();
         n++;
      end
      idle_xy();
      check("clr_len_fetch", n, 19360);

      errs = 0;
      for (int i = 0; i < 19200; i++)
         if (ram[i] !== 3'b101) errs++;
      check("ram_all_101", errs, 0);

      // fetch row 0 on line 525, then display line 0
      for (int x = 0; x <= 160; x++) begin
         yPixel = 10'd525; xPixel = 10'(x);
         tick();
      end
      yPixel = 10'd0; xPixel = 10'd0;
      tick();
      check("row0_x0_r", VGA_R, 8'hFF);
      check("row0_x0_g", VGA_G, 8'h00);
      check("row0_x0_b", VGA_B, 8'hFF);
      xPixel = 10'd320;
      tick();
      check("row0_x320_r", VGA_R, 8'hFF);
      check("row0_x320_b", VGA_B, 8'hFF);
      xPixel = 10'd639;
      tick();
      check("row0_x639_g", VGA_G, 8'h00);
      check("row0_x639_b", VGA_B, 8'hFF);
      xPixel = 10'd700;
      tick();
      check("blank_x700_r", VGA_R, 8'h00);
      check("blank_x700_b", VGA_B, 8'h00);
      yPixel = 10'd500; xPixel = 10'd10;
      tick();
      check("blank_y500_r", VGA_R, 8'h00);
      check("blank_y500_b", VGA_B, 8'h00);

      // clear to black, no fetch overlap
      idle_xy();
      clear_rgb = 3'b000; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      n = 0;
      while (clear_busy === 1'b1 && n < 30000) begin
         tick();
         n++;
      end
      check("clr_len_plain", n, 19200);

      wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd5; wr_rgb = 3'b010;
      mid();
      check("wr_ready", wr_ready, 1);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, 810);
      check("wr_wdata", mem_wdata, 3'b010);
      tick();

      // writer held across the row-5 fetch line
      wr_x = 8'd100; wr_y = 7'd100; wr_rgb = 3'b001;
      stall = 0;
      for (int x = 0; x <= 160; x++) begin
         yPixel = 10'd19; xPixel = 10'(x);
         mid();
         if (x < 160 && wr_ready === 1'b0) stall++;
         if (x == 0) begin
            check("fetch_r5_addr0", mem_addr, 800);
            check("fetch_r5_we0", mem_we, 0);
         end
         if (x == 159) check("fetch_r5_addr159", mem_addr, 959);
         if (x == 160) begin
            check("resume_ready", wr_ready, 1);
            check("resume_we", mem_we, 1);
            check("resume_addr", mem_addr, 16100);
         end
         tick();
      end
      wr_valid = 1'b0;
      idle_xy();
      tick();
      check("stall_cycles", stall, 160);
      check("held_write_kept", ram[16100], 3'b001);

      // pixel (10,5) shows at x 40..43 on lines 20..23
      yPixel = 10'd20; xPixel = 10'd0;
      tick();
      for (int x = 36; x <= 47; x++) begin
         xPixel = 10'(x);
         tick();
         exp_g = (x >= 40 && x <= 43) ? 8'hFF : 8'h00;
         check($sformatf("pix_g_x%0d", x), VGA_G, exp_g);
         check($sformatf("pix_r_x%0d", x), VGA_R, 8'h00);
      end
      yPixel = 10'd23; xPixel = 10'd41;
      tick();
      check("pix_y23_in", VGA_G, 8'hFF);
      xPixel = 10'd44;
      tick();
      check("pix_y23_out", VGA_G, 8'h00);

      // out-of-range write is accepted but dropped
      idle_xy();
      wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_rgb = 3'b111;
      mid();
      check("oor_ready", wr_ready, 1);
      check("oor_we", mem_we, 0);
      tick();
      wr_valid = 1'b0;
      tick();
      check("oor_ram0", ram[0], 3'b000);
      check("oor_ram160", ram[160], 3'b000);

      // reset 100 cycles into a clear
      clear_rgb = 3'b101; clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (99) tick();
      check("midclr_busy", clear_busy, 1);
      reset = 1'b1;
      mid();
      check("midclr_rst_ready", wr_ready, 0);
      tick();
      check("midclr_rst_busy", clear_busy, 0);
      reset = 1'b0;
      mid();
      check("midclr_rel_ready", wr_ready, 1);
      tick();
      check("midclr_stays_idle", clear_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
